aes_round_scheduler: RTL
========================

Name: aes_round_scheduler

Overview:
- Sequences one shared, iterative, combinational AES round core between two requesters.
- Supports 128-, 192- and 256-bit key modes, for both encrypt and decrypt.
- Round-robin arbitration picks a job, holds the 128-bit state register, and drives round index, key-slot index and first/last flags to the core. It then returns the result on a valid/ready response port.
- Replaces the free-running per-mode round counters with one handshaked controller, so the core, key containers and seven-segment display path are shared.

Parameters:
- DATA_W, 128, state/block width.
- RND_W, 4, width of round and key-slot indices (max 14).
- CNT_W, 16, width of completed-job counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  requester 0 job accepted this cycle.
- req0_mode  in  2  00=128, 01=192, 10=256, 11=illegal.
- req0_decrypt  in  1  1=inverse cipher.
- req0_data  in  DATA_W  input block.
- req1_valid / req1_ready / req1_mode / req1_decrypt / req1_data  same as requester 0.
- core_state  out  DATA_W  state presented to round core.
- core_round  out  RND_W  current round 0..Nr.
- core_key_idx  out  RND_W  round-key slot: r for encrypt, Nr-r for decrypt.
- core_mode  out  2  latched mode.
- core_decrypt  out  1  latched direction.
- core_first  out  1  core_round==0 (AddRoundKey only).
- core_last  out  1  core_round==Nr (no MixColumns).
- core_result  in  DATA_W  combinational result of the core for the current inputs.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  DATA_W  final block (zero when rsp_err).
- rsp_id  out  1  requester that owns the response.
- rsp_err  out  1  job had illegal mode 11.
- busy  out  1  state != IDLE.
- done_count  out  CNT_W  successful responses delivered; wraps.

Behaviour:
- Nr is 10 for mode 00, 12 for mode 01, 14 for mode 10. Nr and mode are latched at accept.
- States are IDLE, RUN, DONE.
- Reset (async, reset=0): state=IDLE, round=0, state reg=0, rr_ptr=0, rsp_valid=0, rsp_err=0, rsp_id=0, done_count=0. All core_* outputs are 0 and all reqN_ready are 0.
- IDLE:
  - reqN_ready is combinational and high only in IDLE, for the granted requester only.
  - Grant rule: if only one requester is valid, it wins. If both are valid, requester rr_ptr wins.
  - On accept: latch data, mode, decrypt and id; set rr_ptr = ~grant; round=0.
  - Legal mode: go to RUN. Mode 11: go to DONE with rsp_err=1 and the data reg cleared.
- RUN:
  - Each cycle, state reg <= core_result.
  - If round==Nr, go to DONE; otherwise round <= round+1.
  - Exactly Nr+1 RUN cycles.
- DONE:
  - rsp_valid=1. rsp_data, rsp_id and rsp_err are stable until rsp_valid && rsp_ready.
  - On that handshake: go to IDLE. done_count increments only if rsp_err=0 (wraps at 2^CNT_W).
  - No new job is accepted in the handshake cycle; the earliest accept is the following cycle.
- Latency: accept at cycle T gives first rsp_valid at T+Nr+2 (T+1 for an illegal mode).
- Requester inputs are ignored outside the accept cycle. Changing req data while not ready has no effect.
- A requester that deasserts valid before ready loses nothing; no request is queued.
- core_* outputs are driven from registers only, with no combinational path from req* to core_*.
- Reset asserted mid-RUN or mid-DONE: the job is aborted silently and no response is produced.

Decomposition:
- Shared package aes_pkg:
  - mode encodings MODE_128=2'b00, MODE_192=2'b01, MODE_256=2'b10.
  - NR_128=10, NR_192=12, NR_256=14.
  - state enum IDLE/RUN/DONE.
  - a function nr_of(mode).
- One sub-module is natural: aes_rr_arbiter.
  - Two-way round-robin arbiter: valid[1:0], advance, grant one-hot, pointer register.
  - Reusable for the later key-expansion sharing.

Test Plan:
- Req0 only, mode 00, encrypt, data 00112233445566778899aabbccddeeff, bench core model with key 000102..0f:
  - req0_ready at T, rsp_valid at T+12, rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_id=0, done_count=1.
- Mode 01 encrypt (key 00..17) then mode 10 encrypt (key 00..1f), same data:
  - dda97ca4864cdfe06eaf70a0ec0d7191 after 14 cycles.
  - 8ea2b7ca516745bfeafc49904b496089 after 16 cycles.
  - core_key_idx sequences 0..12 and 0..14.
- Both requesters valid continuously, alternating encrypt/decrypt of the mode-00 ciphertext:
  - grants alternate 0,1,0,1.
  - decrypt returns 00112233445566778899aabbccddeeff.
  - core_key_idx runs 10..0 during decrypt.
- rsp_ready held low 5 cycles in DONE:
  - rsp_data/rsp_id stable, busy=1, both reqN_ready=0.
  - on release, accept on the next cycle, not the same one.
- Req1 mode 11:
  - rsp_valid at T+1, rsp_err=1, rsp_data=0, done_count unchanged.
- reset pulsed low during RUN round 5:
  - immediately busy=0, rsp_valid=0, core_state=0.
  - after release, a new job completes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES scheduling definitions: key-mode encodings, round counts and controller states.
// Nr lookup is pure combinational; the illegal mode maps to zero rounds.
package aes_pkg;

    localparam logic [1:0] MODE_128 = 2'b00;
    localparam logic [1:0] MODE_192 = 2'b01;
    localparam logic [1:0] MODE_256 = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_128: nr_of = 4'(NR_128);
            MODE_192: nr_of = 4'(NR_192);
            MODE_256: nr_of = 4'(NR_256);
            default:  nr_of = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer flips to the loser on advance.
// Zero latency; a requester that drops valid before advance simply loses its grant.
module aes_rr_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Pointer names the requester that wins the next tie: the one not served now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= 1'b0;
        end else if (advance && (|grant)) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/aes_round_scheduler.sv
// Shares one iterative AES round core between two requesters; accept-to-response is Nr+2 cycles (1 for illegal mode).
// Requesters are accepted only in IDLE; the response is held in DONE until rsp_ready.
module aes_round_scheduler
    import aes_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int RND_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_mode,
    input  logic              req0_decrypt,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_mode,
    input  logic              req1_decrypt,
    input  logic [DATA_W-1:0] req1_data,
    output logic [DATA_W-1:0] core_state,
    output logic [RND_W-1:0]  core_round,
    output logic [RND_W-1:0]  core_key_idx,
    output logic [1:0]        core_mode,
    output logic              core_decrypt,
    output logic              core_first,
    output logic              core_last,
    input  logic [DATA_W-1:0] core_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic              busy,
    output logic [CNT_W-1:0]  done_count
);

    sched_state_t      state_q;
    logic [RND_W-1:0]  round_q;
    logic [RND_W-1:0]  nr_q;
    logic [DATA_W-1:0] data_q;
    logic [1:0]        mode_q;
    logic              dec_q;
    logic              id_q;
    logic              err_q;
    logic              rsp_valid_q;
    logic [CNT_W-1:0]  done_q;

    logic [1:0]        grant;
    logic              accept;
    logic              gsel;
    logic [1:0]        sel_mode;
    logic              sel_dec;
    logic [DATA_W-1:0] sel_data;
    logic              in_run;

    assign accept = (state_q == IDLE) && (|grant);

    aes_rr_arbiter u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid   ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant)
    );

    assign gsel     = grant[1];
    assign sel_mode = gsel ? req1_mode    : req0_mode;
    assign sel_dec  = gsel ? req1_decrypt : req0_decrypt;
    assign sel_data = gsel ? req1_data    : req0_data;

    // Ready is qualified by reset so no handshake can be signalled while held in reset.
    assign req0_ready = reset & (state_q == IDLE) & grant[0];
    assign req1_ready = reset & (state_q == IDLE) & grant[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            round_q     <= '0;
            nr_q        <= '0;
            data_q      <= '0;
            mode_q      <= 2'b00;
            dec_q       <= 1'b0;
            id_q        <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            done_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        mode_q  <= sel_mode;
                        dec_q   <= sel_dec;
                        id_q    <= gsel;
                        nr_q    <= RND_W'(nr_of(sel_mode));
                        round_q <= '0;
                        if (sel_mode == MODE_ILL) begin
                            data_q      <= '0;
                            err_q       <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            data_q  <= sel_data;
                            err_q   <= 1'b0;
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    data_q <= core_result;
                    if (round_q == nr_q) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        round_q <= round_q + RND_W'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        err_q       <= 1'b0;
                        state_q     <= IDLE;
                        if (!err_q) begin
                            done_q <= done_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Round-indexed core controls are only meaningful while iterating; zero elsewhere.
    assign in_run       = (state_q == RUN);
    assign core_state   = data_q;
    assign core_round   = round_q;
    assign core_key_idx = in_run ? (dec_q ? (nr_q - round_q) : round_q) : '0;
    assign core_mode    = mode_q;
    assign core_decrypt = dec_q;
    assign core_first   = in_run && (round_q == '0);
    assign core_last    = in_run && (round_q == nr_q);

    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = data_q;
    assign rsp_id     = id_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != IDLE);
    assign done_count = done_q;

endmodule
